// File: rtl/xbar_rr_fifo.sv
// Master/slave crossbar: a DEPTH-entry FIFO per (slave, master) pair, a round-robin
// request arbiter and handshake FSM per slave, and a lowest-index return arbiter per master.
module xbar_rr_fifo #(
  parameter int MASTERS = 4,
  parameter int SLAVES  = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [MASTERS-1:0]                            m_req,
  input  logic [MASTERS-1:0]                            m_cmd,
  input  logic [MASTERS-1:0][AW-1:0]                    m_addr,
  input  logic [MASTERS-1:0][DW-1:0]                    m_wdata,
  output logic [MASTERS-1:0]                            m_gnt,
  output logic [MASTERS-1:0]                            m_ack,
  output logic [MASTERS-1:0]                            m_resp,
  output logic [MASTERS-1:0][DW-1:0]                    m_rdata,
  output logic [MASTERS-1:0][$clog2(SLAVES)-1:0]        m_sid,
  output logic [SLAVES-1:0]                             s_req,
  output logic [SLAVES-1:0]                             s_cmd,
  output logic [SLAVES-1:0][AW-$clog2(SLAVES)-1:0]      s_addr,
  output logic [SLAVES-1:0][DW-1:0]                     s_wdata,
  input  logic [SLAVES-1:0]                             s_ack,
  input  logic [SLAVES-1:0]                             s_resp,
  input  logic [SLAVES-1:0][DW-1:0]                     s_rdata
);

  localparam int SB  = $clog2(SLAVES);
  localparam int LAW = AW - SB;
  localparam int MW  = $clog2(MASTERS);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RET} st_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic                         r_f_cmd   [SLAVES][MASTERS][DEPTH];
  logic [LAW-1:0]               r_f_addr  [SLAVES][MASTERS][DEPTH];
  logic [DW-1:0]                r_f_wdata [SLAVES][MASTERS][DEPTH];
  logic [CW-1:0]                r_cnt     [SLAVES][MASTERS];
  logic [PW-1:0]                r_wp      [SLAVES][MASTERS];
  logic [PW-1:0]                r_rp      [SLAVES][MASTERS];

  st_t                          r_state   [SLAVES];
  st_t                          w_nx      [SLAVES];
  logic [MW-1:0]                r_last    [SLAVES];
  logic [MW-1:0]                r_owner   [SLAVES];
  logic [DW-1:0]                r_rdata   [SLAVES];
  logic [SLAVES-1:0]            r_s_cmd;
  logic [SLAVES-1:0][LAW-1:0]   r_s_addr;
  logic [SLAVES-1:0][DW-1:0]    r_s_wdata;

  logic [MASTERS-1:0]           r_m_ack;
  logic [MASTERS-1:0]           r_m_resp;
  logic [MASTERS-1:0][DW-1:0]   r_m_rdata;
  logic [MASTERS-1:0][SB-1:0]   r_m_sid;

  logic [SB-1:0]                w_sid     [MASTERS];
  logic [MASTERS-1:0]           w_gnt;
  logic [SLAVES-1:0][MASTERS-1:0] w_push;
  logic [SLAVES-1:0][MASTERS-1:0] w_pop;
  logic [SLAVES-1:0]            w_any;
  logic [MW-1:0]                w_win     [SLAVES];
  logic [SLAVES-1:0]            w_sel;
  logic [MASTERS-1:0]           w_rany;
  logic [SB-1:0]                w_rsel    [MASTERS];
  logic [SLAVES-1:0]            w_ret_go;

  // Accept: full is taken from the registered count, so a same-cycle pop never frees a slot
  always_comb begin
    w_gnt  = '0;
    w_push = '0;
    for (int m = 0; m < MASTERS; m++) begin
      w_sid[m] = m_addr[m][AW-1 -: SB];
      w_gnt[m] = m_req[m] && (r_cnt[w_sid[m]][m] != CW'(DEPTH));
      for (int s = 0; s < SLAVES; s++)
        w_push[s][m] = w_gnt[m] && (w_sid[m] == SB'(s));
    end
  end

  // Round-robin: descending scan so the smallest offset from last+1 wins
  always_comb begin
    w_any = '0;
    w_sel = '0;
    w_pop = '0;
    for (int s = 0; s < SLAVES; s++) begin
      w_win[s] = '0;
      for (int off = MASTERS; off >= 1; off--) begin
        int idx;
        idx = (int'(r_last[s]) + off) % MASTERS;
        if (r_cnt[s][idx] != '0) begin
          w_any[s] = 1'b1;
          w_win[s] = MW'(idx);
        end
      end
      w_sel[s] = (r_state[s] == ST_IDLE) && w_any[s];
      for (int m = 0; m < MASTERS; m++)
        w_pop[s][m] = w_sel[s] && (w_win[s] == MW'(m));
    end
  end

  always_comb begin
    w_rany   = '0;
    w_ret_go = '0;
    for (int m = 0; m < MASTERS; m++) begin
      w_rsel[m] = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if (r_state[s] == ST_RET && r_owner[s] == MW'(m)) begin
          w_rany[m] = 1'b1;
          w_rsel[m] = SB'(s);
        end
      end
    end
    for (int s = 0; s < SLAVES; s++)
      w_ret_go[s] = (r_state[s] == ST_RET) && (w_rsel[r_owner[s]] == SB'(s));
  end

  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      w_nx[s] = r_state[s];
      case (r_state[s])
        ST_IDLE: if (w_any[s])     w_nx[s] = ST_REQ;
        ST_REQ:  if (s_ack[s])     w_nx[s] = r_s_cmd[s] ? ST_RET : ST_WAIT;
        ST_WAIT: if (s_resp[s])    w_nx[s] = ST_RET;
        ST_RET:  if (w_ret_go[s])  w_nx[s] = ST_IDLE;
        default:                   w_nx[s] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SLAVES; s++)
      r_state[s] <= rst ? ST_IDLE : w_nx[s];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SLAVES; s++) begin
        for (int m = 0; m < MASTERS; m++) begin
          r_cnt[s][m] <= '0;
          r_wp[s][m]  <= '0;
          r_rp[s][m]  <= '0;
        end
        r_last[s]  <= MW'(MASTERS - 1);
        r_owner[s] <= '0;
      end
      r_s_cmd   <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_ack   <= '0;
      r_m_resp  <= '0;
      r_m_rdata <= '0;
      r_m_sid   <= '0;
    end else begin
      for (int s = 0; s < SLAVES; s++) begin
        for (int m = 0; m < MASTERS; m++) begin
          if (w_push[s][m]) r_wp[s][m] <= ptr_inc(r_wp[s][m]);
          if (w_pop[s][m])  r_rp[s][m] <= ptr_inc(r_rp[s][m]);
          case ({w_push[s][m], w_pop[s][m]})
            2'b10:   r_cnt[s][m] <= r_cnt[s][m] + 1'b1;
            2'b01:   r_cnt[s][m] <= r_cnt[s][m] - 1'b1;
            default: r_cnt[s][m] <= r_cnt[s][m];
          endcase
        end
        if (w_sel[s]) begin
          r_last[s]    <= w_win[s];
          r_owner[s]   <= w_win[s];
          r_s_cmd[s]   <= r_f_cmd[s][w_win[s]][r_rp[s][w_win[s]]];
          r_s_addr[s]  <= r_f_addr[s][w_win[s]][r_rp[s][w_win[s]]];
          r_s_wdata[s] <= r_f_wdata[s][w_win[s]][r_rp[s][w_win[s]]];
        end
      end
      // Return path: one registered completion per master per cycle
      for (int m = 0; m < MASTERS; m++) begin
        r_m_ack[m]  <= w_rany[m] && r_s_cmd[w_rsel[m]];
        r_m_resp[m] <= w_rany[m] && !r_s_cmd[w_rsel[m]];
        if (w_rany[m]) begin
          r_m_sid[m] <= w_rsel[m];
          if (!r_s_cmd[w_rsel[m]]) r_m_rdata[m] <= r_rdata[w_rsel[m]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SLAVES; s++) begin
      for (int m = 0; m < MASTERS; m++) begin
        if (w_push[s][m]) begin
          r_f_cmd[s][m][r_wp[s][m]]   <= m_cmd[m];
          r_f_addr[s][m][r_wp[s][m]]  <= m_addr[m][LAW-1:0];
          r_f_wdata[s][m][r_wp[s][m]] <= m_wdata[m];
        end
      end
      if (r_state[s] == ST_WAIT && s_resp[s]) r_rdata[s] <= s_rdata[s];
    end
  end

  always_comb begin
    s_req = '0;
    for (int s = 0; s < SLAVES; s++) s_req[s] = (r_state[s] == ST_REQ);
  end

  assign m_gnt   = w_gnt;
  assign m_ack   = r_m_ack;
  assign m_resp  = r_m_resp;
  assign m_rdata = r_m_rdata;
  assign m_sid   = r_m_sid;
  assign s_cmd   = r_s_cmd;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;

endmodule

// File: tb/tb_xbar_rr_fifo.sv
// Directed bench for xbar_rr_fifo: vector table of single transactions plus
// hand-written sequences for arbitration, back-pressure, return contention and reset.
module tb_xbar_rr_fifo;
  localparam int M = 4, S = 4, DW = 32, AW = 32, DEPTH = 2, SB = 2, LAW = 30;

  logic                     clk, rst;
  logic [M-1:0]             m_req, m_cmd, m_gnt, m_ack, m_resp;
  logic [M-1:0][AW-1:0]     m_addr;
  logic [M-1:0][DW-1:0]     m_wdata, m_rdata;
  logic [M-1:0][SB-1:0]     m_sid;
  logic [S-1:0]             s_req, s_cmd, s_ack, s_resp;
  logic [S-1:0][LAW-1:0]    s_addr;
  logic [S-1:0][DW-1:0]     s_wdata, s_rdata;

  int n_vec = 0, n_bad = 0;

  xbar_rr_fifo #(.MASTERS(M), .SLAVES(S), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata), .m_sid(m_sid),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    int          m;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackdly;
    logic [1:0]  sid;
    logic [29:0] laddr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic do_txn(input vec_t v, input string tag);
    logic held;
    m_req[v.m] = 1'b1; m_cmd[v.m] = v.cmd; m_addr[v.m] = v.addr; m_wdata[v.m] = v.wdata;
    mid(); chk($sformatf("%s.gnt", tag), m_gnt, 4'b1 << v.m);
    cyc(); m_req = '0;
    mid(); chk($sformatf("%s.sreq_e0", tag), s_req, 0);
    cyc();
    mid();
    chk($sformatf("%s.sreq", tag), s_req, 4'b1 << v.sid);
    chk($sformatf("%s.saddr", tag), s_addr[v.sid], v.laddr);
    chk($sformatf("%s.scmd", tag), s_cmd[v.sid], v.cmd);
    if (v.cmd) chk($sformatf("%s.swdata", tag), s_wdata[v.sid], v.wdata);
    held = 1'b1;
    for (int k = 0; k < v.ackdly; k++) begin
      cyc(); mid(); held &= s_req[v.sid];
    end
    if (v.ackdly > 0) chk($sformatf("%s.sreq_held", tag), held, 1);
    s_ack[v.sid] = 1'b1;
    cyc(); s_ack = '0;
    if (v.cmd) begin
      mid(); chk($sformatf("%s.ack_early", tag), m_ack, 0);
      cyc(); mid();
      chk($sformatf("%s.ack", tag), m_ack, 4'b1 << v.m);
      chk($sformatf("%s.ack_sid", tag), m_sid[v.m], v.sid);
      chk($sformatf("%s.ack_noresp", tag), m_resp, 0);
      cyc(); mid(); chk($sformatf("%s.ack_pulse", tag), m_ack, 0);
    end else begin
      s_resp[v.sid] = 1'b1; s_rdata[v.sid] = v.rdata;
      mid(); chk($sformatf("%s.sreq_drop", tag), s_req, 0);
      cyc(); s_resp = '0; s_rdata[v.sid] = 32'h0BAD_0BAD;
      mid(); chk($sformatf("%s.resp_early", tag), m_resp, 0);
      cyc(); mid();
      chk($sformatf("%s.resp", tag), m_resp, 4'b1 << v.m);
      chk($sformatf("%s.rdata", tag), m_rdata[v.m], v.rdata);
      chk($sformatf("%s.resp_sid", tag), m_sid[v.m], v.sid);
      chk($sformatf("%s.resp_noack", tag), m_ack, 0);
      cyc(); mid(); chk($sformatf("%s.resp_pulse", tag), m_resp, 0);
    end
    cyc();
  endtask

  initial begin
    int   order[$];
    logic [29:0] addrs[$];
    int   got, acks, a0, a2, serves;
    logic resp_pend, bad;
    logic [1:0] cur;
    vec_t v5;

    tbl[0] = '{0, 1'b1, 32'h4000_0010, 32'hA5A5_A5A5, 32'h0,         3, 2'd1, 30'h0000_0010};
    tbl[1] = '{1, 1'b0, 32'hC000_1234, 32'h0,         32'hDEAD_BEEF, 0, 2'd3, 30'h0000_1234};
    tbl[2] = '{3, 1'b1, 32'h8ABC_DEF0, 32'h1234_5678, 32'h0,         1, 2'd2, 30'h0ABC_DEF0};
    tbl[3] = '{2, 1'b0, 32'h3FFF_FFFC, 32'h0,         32'hCAFE_F00D, 2, 2'd0, 30'h3FFF_FFFC};
    tbl[4] = '{0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h8000_0001, 0, 2'd3, 30'h3FFF_FFFF};
    tbl[5] = '{1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,         1, 2'd0, 30'h0000_0000};

    rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_resp = '0; s_rdata = '0;
    repeat (3) cyc();
    rst = 1'b0;
    mid();
    chk("rst.m_ack", m_ack, 0);
    chk("rst.m_resp", m_resp, 0);
    chk("rst.m_rdata", m_rdata, 0);
    chk("rst.m_sid", m_sid, 0);
    chk("rst.s_req", s_req, 0);
    chk("rst.s_cmd", s_cmd, 0);
    chk("rst.s_addr", s_addr, 0);
    chk("rst.s_wdata", s_wdata, 0);
    chk("rst.m_gnt", m_gnt, 0);
    cyc();

    for (int i = 0; i < 6; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // All four masters read slave 2 in the same cycle
    for (int i = 0; i < M; i++) begin
      m_req[i] = 1'b1; m_cmd[i] = 1'b0; m_addr[i] = 32'h8000_0000 | (i << 4);
    end
    mid(); chk("rr.gnt_all", m_gnt, 4'hF);
    cyc(); m_req = '0;
    got = 0; resp_pend = 1'b0; cur = '0;
    for (int t = 0; t < 60 && got < 4; t++) begin
      s_ack[2] = 1'b0; s_resp[2] = 1'b0;
      if (resp_pend) begin
        s_resp[2] = 1'b1; s_rdata[2] = 32'hD000_0000 | 32'(cur); resp_pend = 1'b0;
      end else if (s_req[2]) begin
        s_ack[2] = 1'b1; cur = s_addr[2][5:4]; order.push_back(int'(cur)); resp_pend = 1'b1;
      end
      for (int m = 0; m < M; m++) begin
        if (m_resp[m]) begin
          chk($sformatf("rr.rdata%0d", m), m_rdata[m], 32'hD000_0000 | m);
          chk($sformatf("rr.sid%0d", m), m_sid[m], 2);
          got++;
        end
      end
      cyc();
    end
    s_ack = '0; s_resp = '0;
    chk("rr.resp_count", got, 4);
    chk("rr.order_len", order.size(), 4);
    for (int k = 0; k < order.size(); k++) chk($sformatf("rr.order%0d", k), order[k], k);
    repeat (2) cyc();

    // FIFO full: slave 0 held busy by M0, M1 pushes three writes
    m_req[0] = 1'b1; m_cmd[0] = 1'b1; m_addr[0] = 32'h0000_0100; m_wdata[0] = 32'h0000_AAAA;
    cyc(); m_req[0] = 1'b0;
    cyc(); mid();
    chk("full.m0_busy", {s_req[0], s_addr[0]}, {1'b1, 30'h100});
    cyc();
    m_req[1] = 1'b1; m_cmd[1] = 1'b1; m_addr[1] = 32'h0000_0200; m_wdata[1] = 32'h1000_0000;
    mid(); chk("full.gnt1", m_gnt[1], 1);
    cyc(); m_addr[1] = 32'h0000_0204; m_wdata[1] = 32'h1000_0001;
    mid(); chk("full.gnt2", m_gnt[1], 1);
    cyc(); m_addr[1] = 32'h0000_0208; m_wdata[1] = 32'h1000_0002;
    mid(); chk("full.gnt3", m_gnt[1], 0);
    cyc(); mid(); chk("full.gnt3_hold", m_gnt[1], 0);
    s_ack[0] = 1'b1;
    cyc(); s_ack[0] = 1'b0;
    mid(); chk("full.gnt_ret", m_gnt[1], 0);
    cyc(); mid();
    chk("full.m0_ack", m_ack, 4'b0001);
    chk("full.m0_sid", m_sid[0], 0);
    chk("full.gnt_idle", m_gnt[1], 0);
    cyc(); mid(); chk("full.gnt_after_pop", m_gnt[1], 1);
    cyc(); m_req[1] = 1'b0;
    acks = 0;
    for (int t = 0; t < 40 && acks < 3; t++) begin
      s_ack[0] = 1'b0;
      if (s_req[0]) begin s_ack[0] = 1'b1; addrs.push_back(s_addr[0]); end
      if (m_ack[1]) acks++;
      cyc();
    end
    s_ack = '0;
    chk("full.acks", acks, 3);
    chk("full.nserved", addrs.size(), 3);
    for (int k = 0; k < addrs.size() && k < 3; k++)
      chk($sformatf("full.addr%0d", k), addrs[k], 30'h200 + 30'(4 * k));
    repeat (2) cyc();

    // Two slaves complete to M2 in the same cycle
    m_req[2] = 1'b1; m_cmd[2] = 1'b0; m_addr[2] = 32'h0000_0040;
    mid(); chk("ret.gnt_s0", m_gnt[2], 1);
    cyc(); m_addr[2] = 32'hC000_0040;
    mid(); chk("ret.gnt_s3", m_gnt[2], 1);
    cyc(); m_req[2] = 1'b0;
    mid(); chk("ret.sreq0", s_req, 4'b0001);
    s_ack[0] = 1'b1;
    cyc(); s_ack[0] = 1'b0;
    mid(); chk("ret.sreq3", s_req, 4'b1000);
    s_ack[3] = 1'b1;
    cyc(); s_ack[3] = 1'b0;
    s_resp[0] = 1'b1; s_resp[3] = 1'b1; s_rdata[0] = 32'h11; s_rdata[3] = 32'h33;
    cyc(); s_resp = '0;
    mid(); chk("ret.none_yet", m_resp, 0);
    cyc(); mid();
    chk("ret.first", m_resp, 4'b0100);
    chk("ret.first_data", m_rdata[2], 32'h11);
    chk("ret.first_sid", m_sid[2], 0);
    cyc(); mid();
    chk("ret.second", m_resp, 4'b0100);
    chk("ret.second_data", m_rdata[2], 32'h33);
    chk("ret.second_sid", m_sid[2], 3);
    cyc(); mid(); chk("ret.done", m_resp, 0);
    cyc();

    // Reset while slave 1 waits for a response with two entries queued
    for (int i = 0; i < 3; i++) begin
      m_req[i] = 1'b1; m_cmd[i] = 1'b0; m_addr[i] = 32'h4000_0000 | (i << 4);
    end
    mid(); chk("mrst.gnt", m_gnt, 4'b0111);
    cyc(); m_req = '0;
    cyc(); mid(); chk("mrst.sreq", s_req, 4'b0010);
    s_ack[1] = 1'b1;
    cyc(); s_ack[1] = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    mid();
    chk("mrst.sreq_off", s_req, 0);
    chk("mrst.no_resp", m_resp, 0);
    cyc();
    s_resp[1] = 1'b1; s_rdata[1] = 32'h0000_0BAD;
    bad = 1'b0;
    for (int t = 0; t < 8; t++) begin
      cyc(); s_resp = '0;
      bad |= (m_resp != 0) || (m_ack != 0) || (s_req != 0);
    end
    chk("mrst.quiet", bad, 0);
    v5 = '{3, 1'b0, 32'h4000_0080, 32'h0, 32'h5555_AAAA, 1, 2'd1, 30'h0000_0080};
    do_txn(v5, "mrst.new");

    // Masters 0 and 2 saturate slave 3
    m_req[0] = 1'b1; m_cmd[0] = 1'b1; m_addr[0] = 32'hC000_0000; m_wdata[0] = 32'h0;
    m_req[2] = 1'b1; m_cmd[2] = 1'b1; m_addr[2] = 32'hC000_0008; m_wdata[2] = 32'h2;
    order.delete();
    serves = 0; a0 = 0; a2 = 0;
    for (int t = 0; t < 300 && serves < 20; t++) begin
      s_ack[3] = 1'b0;
      if (s_req[3]) begin
        s_ack[3] = 1'b1; order.push_back(s_addr[3][3] ? 2 : 0); serves++;
      end
      if (m_ack[0]) a0++;
      if (m_ack[2]) a2++;
      if (serves >= 20) m_req = '0;
      cyc();
    end
    m_req = '0;
    for (int t = 0; t < 60; t++) begin
      s_ack[3] = 1'b0;
      if (s_req[3]) begin s_ack[3] = 1'b1; serves++; end
      if (m_ack[0]) a0++;
      if (m_ack[2]) a2++;
      cyc();
    end
    s_ack = '0;
    chk("sat.nserved", order.size(), 20);
    for (int k = 0; k < order.size(); k++)
      chk($sformatf("sat.order%0d", k), order[k], (k % 2 == 0) ? 0 : 2);
    chk("sat.acks_match", a0 + a2, serves);
    chk("sat.idle", s_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
